matrix_column_scanner: RTL and testbench
========================================

Name: matrix_column_scanner

Overview:
Sequential column-scan controller for the LED matrix panel. It holds a double-buffered frame image (7 columns × ROWS rows) and cycles through the columns at a prescaled rate. For each column it drives the 3-bit column select code into the downstream 3-to-7 column decoder and drives the matching row pattern onto the row lines. A blanking interval between columns suppresses ghosting, and the buffer swap is synchronised to the frame boundary.

Parameters:
PRESCALE, 1000, clock cycles a column stays lit (≥1)
BLANK_CYCLES, 2, clock cycles of all-off between columns (≥0; 0 = no blanking)
ROWS, 5, row lines per column

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; low forces the panel dark
wr_en  input  1  write strobe into back buffer
wr_col  input  3  back-buffer column address 0..6; value 7 ignored
wr_data  input  ROWS  row pattern written at wr_col (bit i = row i, 1 = lit)
swap_req  input  1  one-cycle request to swap front/back at the next frame boundary
sel1  output  1  column code MSB to decoder
sel2  output  1  column code middle bit
sel3  output  1  column code LSB
row  output  ROWS  row pattern of the lit column
frame_tick  output  1  one-cycle pulse at end of each frame
swap_done  output  1  one-cycle pulse in the cycle the swap takes effect

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: {sel1,sel2,sel3}=000, row=0, frame_tick=0, swap_done=0, both buffers cleared, col=0, prescaler=0, swap pending=0, state IDLE.
- Column code: column k (0..6) is driven as code k+1, with sel1 as MSB (k=3 → 100). Code 000 selects no column and is the dark/blank code.
- All outputs are registered and change only on clk edges.
- FSM states: IDLE, SCAN, BLANK.
  - IDLE: sel=000, row=0. When en=1, go to SCAN with col=0 and prescaler=0.
  - SCAN: sel=col+1, row=front[col]. Prescaler counts 0..PRESCALE-1. At PRESCALE-1:
    - if BLANK_CYCLES>0, go to BLANK;
    - otherwise advance the column and stay in SCAN.
  - BLANK: sel=000, row=0 for exactly BLANK_CYCLES cycles, then advance the column and go to SCAN.
- Column advance: col=6 wraps to 0. Column period = PRESCALE+BLANK_CYCLES cycles; frame = 7× column period.
- Frame boundary = the advance from col 6 to 0. In that cycle:
  - frame_tick=1;
  - if swap is pending: front/back exchange, swap_done=1, pending cleared.
  - The first SCAN cycle of col 0 shows the new front buffer.
- swap_req=1 sets pending.
  - A repeated request while pending has no extra effect (one swap only).
  - A request in the same cycle as a swap re-arms pending for the next frame.
- Writes:
  - wr_en=1 with wr_col≤6 writes wr_data into back[wr_col] at the clock edge.
  - wr_col=7 is ignored.
  - A write coinciding with a swap lands in the pre-swap back buffer, which becomes front.
  - Writes never alter the front buffer directly.
- en=1→0 in any state: next cycle goes to IDLE with sel=000, row=0; col and prescaler reset to 0. Pending swap and buffer contents are retained. No frame_tick or swap occurs while in IDLE.
- Asserting rst_n mid-frame clears everything immediately, regardless of clk.

Test Plan:
- PRESCALE=4, BLANK_CYCLES=1, en=1 after reset → sel sequence 001×4, 000×1, 010×4, 000, … 111×4, 000, then 001. frame_tick pulses once every 35 cycles, coincident with the 7→1 transition.
- Write back[3]=10101 with wr_en, pulse swap_req mid-frame → swap_done and frame_tick both pulse at the next boundary. row=10101 while sel=100; row=00000 on all other columns. Before the swap, row stays 0 at sel=100.
- wr_col=7 with wr_data=11111, then swap → no column shows 11111; all rows remain 0.
- Drop en during column 5 SCAN → next cycle sel=000, row=0. Re-raise en → scan restarts at sel=001 with a full 4-cycle dwell.
- swap_req pulsed twice within one frame, again in the swap cycle → exactly one swap at the first boundary and a second swap at the following boundary.
- BLANK_CYCLES=0 → sel steps 001→010 directly with no 000 cycle; frame = 28 cycles. rst_n low mid-SCAN → outputs zero asynchronously.

Source files
------------

// File: rtl/matrix_column_scanner.sv
// rtl/matrix_column_scanner.sv - column-scan controller for a 7-column LED matrix
//
// Double-buffered frame image (7 columns x ROWS rows). Each column is lit for
// PRESCALE cycles, followed by BLANK_CYCLES all-off cycles, and the columns are
// visited in order 0..6. The front/back exchange only happens at the 6->0 wrap.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   en                 scan enable; low forces the panel dark and restarts at column 0
//   wr_en/wr_col/wr_data  back-buffer write port (wr_col = 7 ignored)
//   swap_req           request a front/back exchange at the next frame boundary
//   sel1/sel2/sel3     column code to the 3-to-7 decoder (column k -> k+1, 000 = dark)
//   row                row pattern of the lit column
//   frame_tick         one-cycle pulse on the first cycle of a new frame
//   swap_done          one-cycle pulse on the first cycle showing the swapped buffer

module matrix_column_scanner #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int ROWS         = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [2:0]      wr_col,
  input  logic [ROWS-1:0] wr_data,
  input  logic            swap_req,
  output logic            sel1,
  output logic            sel2,
  output logic            sel3,
  output logic [ROWS-1:0] row,
  output logic            frame_tick,
  output logic            swap_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

  state_t          state, state_n;
  logic [2:0]      col, col_n;
  logic [PW-1:0]   presc, presc_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic            pending, pending_n;
  logic            fsel, fsel_n;        // index of the bank currently shown (front)
  logic            advance, wrap, do_swap, wr_ok;
  logic [2:0]      sel_q, sel_n;
  logic [ROWS-1:0] row_n;

  // Both banks; the back bank is always mem[!fsel].
  logic [1:0][6:0][ROWS-1:0] mem;

  always_comb begin
    state_n = state;
    col_n   = col;
    presc_n = presc;
    bcnt_n  = bcnt;
    advance = 1'b0;
    case (state)
      IDLE: begin
        state_n = SCAN;
        col_n   = 3'd0;
        presc_n = '0;
      end
      SCAN: begin
        if (presc == PMAX) begin
          presc_n = '0;
          if (BLANK_CYCLES > 0) begin
            state_n = BLANK;
            bcnt_n  = '0;
          end else begin
            advance = 1'b1;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      BLANK: begin
        if (bcnt == BMAX) advance = 1'b1;
        else              bcnt_n  = bcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (advance) begin
      state_n = SCAN;
      col_n   = (col == 3'd6) ? 3'd0 : col + 3'd1;
    end
    wrap = advance && (col == 3'd6);

    // Disable overrides everything: dark panel, scan position forgotten.
    if (!en) begin
      state_n = IDLE;
      col_n   = 3'd0;
      presc_n = '0;
      bcnt_n  = '0;
      wrap    = 1'b0;
    end

    do_swap   = wrap && pending;
    // A request landing on the swap cycle arms the following frame.
    pending_n = do_swap ? swap_req : (pending | swap_req);
    fsel_n    = fsel ^ do_swap;
    wr_ok     = wr_en && (wr_col != 3'd7);

    sel_n = 3'd0;
    row_n = '0;
    if (state_n == SCAN) begin
      sel_n = col_n + 3'd1;
      // A write into the bank that becomes front on this edge must be visible at once.
      if (wr_ok && (!fsel == fsel_n) && (wr_col == col_n)) row_n = wr_data;
      else                                                 row_n = mem[fsel_n][col_n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= 3'd0;
      presc      <= '0;
      bcnt       <= '0;
      pending    <= 1'b0;
      fsel       <= 1'b0;
      mem        <= '0;
      sel_q      <= 3'd0;
      row        <= '0;
      frame_tick <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      presc      <= presc_n;
      bcnt       <= bcnt_n;
      pending    <= pending_n;
      fsel       <= fsel_n;
      if (wr_ok) mem[!fsel][wr_col] <= wr_data;
      sel_q      <= sel_n;
      row        <= row_n;
      frame_tick <= wrap;
      swap_done  <= do_swap;
    end
  end

  assign sel1 = sel_q[2];
  assign sel2 = sel_q[1];
  assign sel3 = sel_q[0];

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb/tb_matrix_column_scanner.sv - self-checking bench for matrix_column_scanner

module tb_matrix_column_scanner;

  localparam int P   = 4;
  localparam int B   = 1;
  localparam int R   = 5;
  localparam int PER = P + B;
  localparam int FR  = 7 * PER;
  localparam int FR1 = 7 * P;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
  logic [2:0]   wr_col = 3'd0;
  logic [R-1:0] wr_data = '0;
  logic         en1 = 1'b0, n_wr_en = 1'b0, n_swap = 1'b0;
  logic [2:0]   n_wr_col = 3'd0;
  logic [R-1:0] n_wr_data = '0;

  logic a_s1, a_s2, a_s3, a_ft, a_sd;
  logic b_s1, b_s2, b_s3, b_ft, b_sd;
  logic [R-1:0] a_row, b_row;
  wire  [2:0] a_sel = {a_s1, a_s2, a_s3};
  wire  [2:0] b_sel = {b_s1, b_s2, b_s3};

  matrix_column_scanner #(.PRESCALE(P), .BLANK_CYCLES(B), .ROWS(R)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_col(wr_col),
    .wr_data(wr_data), .swap_req(swap_req), .sel1(a_s1), .sel2(a_s2), .sel3(a_s3),
    .row(a_row), .frame_tick(a_ft), .swap_done(a_sd));

  matrix_column_scanner #(.PRESCALE(P), .BLANK_CYCLES(0), .ROWS(R)) dut_nb (
    .clk(clk), .rst_n(rst_n), .en(en1), .wr_en(n_wr_en), .wr_col(n_wr_col),
    .wr_data(n_wr_data), .swap_req(n_swap), .sel1(b_s1), .sel2(b_s2), .sel3(b_s3),
    .row(b_row), .frame_tick(b_ft), .swap_done(b_sd));

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  // Reference model: scan position is just "cycles since enable" (t).
  int           t, t1;
  bit           run, run1, pend, e_ft, e_sd, e_ft1;
  logic [R-1:0] fm [7];
  logic [R-1:0] bk [7];

  function automatic logic [2:0] exp_sel();
    if (!run || (t % PER) >= P) return 3'd0;
    return 3'(((t / PER) % 7) + 1);
  endfunction

  function automatic logic [R-1:0] exp_row();
    if (!run || (t % PER) >= P) return '0;
    return fm[(t / PER) % 7];
  endfunction

  function automatic logic [2:0] exp_sel1();
    if (!run1) return 3'd0;
    return 3'(((t1 / P) % 7) + 1);
  endfunction

  task automatic model_clear();
    run = 0; run1 = 0; t = 0; t1 = 0; pend = 0;
    e_ft = 0; e_sd = 0; e_ft1 = 0;
    for (int i = 0; i < 7; i++) begin fm[i] = '0; bk[i] = '0; end
  endtask

  // Advance the model by one clock using the inputs now applied, then clock the DUTs.
  task automatic tick();
    logic [R-1:0] tmp;
    bit boundary;
    boundary = 0;
    e_ft = 0; e_sd = 0; e_ft1 = 0;
    if (wr_en && wr_col != 3'd7) bk[wr_col] = wr_data;
    if (!en) run = 0;
    else if (!run) begin run = 1; t = 0; end
    else begin t++; boundary = (t % FR == 0); end
    if (boundary && pend) begin
      for (int i = 0; i < 7; i++) begin tmp = fm[i]; fm[i] = bk[i]; bk[i] = tmp; end
      e_sd = 1;
      pend = swap_req;
    end else begin
      pend = pend | swap_req;
    end
    e_ft = boundary;
    if (!en1) run1 = 0;
    else if (!run1) begin run1 = 1; t1 = 0; end
    else begin t1++; e_ft1 = (t1 % FR1 == 0); end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    en = 0; en1 = 0; wr_en = 0; swap_req = 0;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_sel, a_row, a_ft, a_sd} !== '0) $display("FAIL reset_a: got sel=%b row=%b ft=%b sd=%b want 0", a_sel, a_row, a_ft, a_sd);
    else passed++;
    checks++;
    if ({b_sel, b_row, b_ft, b_sd} !== '0) $display("FAIL reset_b: got sel=%b row=%b ft=%b sd=%b want 0", b_sel, b_row, b_ft, b_sd);
    else passed++;
  endtask

  task automatic test_scan_sequence();
    int nft;
    nft = 0;
    en = 1;
    repeat (2 * FR + 1) begin
      tick();
      nft += a_ft;
      checks++;
      if ({a_sel, a_row, a_ft, a_sd} !== {exp_sel(), exp_row(), e_ft, e_sd})
        $display("FAIL scan t=%0d: got sel=%b row=%b ft=%b sd=%b want sel=%b row=%b ft=%b sd=%b",
                 t, a_sel, a_row, a_ft, a_sd, exp_sel(), exp_row(), e_ft, e_sd);
      else passed++;
    end
    checks++;
    if (nft !== 2) $display("FAIL scan_tick_count: got %0d want 2", nft);
    else passed++;
  endtask

  task automatic test_swap_write();
    int nsd;
    bit seen;
    nsd = 0; seen = 0;
    wr_en = 1; wr_col = 3'd3; wr_data = 5'b10101;
    tick();
    wr_en = 0;
    repeat (3) tick();
    swap_req = 1;
    tick();
    swap_req = 0;
    repeat (2 * FR) begin
      tick();
      nsd += a_sd;
      if (a_sel == 3'b100 && a_row == 5'b10101) seen = 1;
      checks++;
      if ({a_sel, a_row, a_ft, a_sd} !== {exp_sel(), exp_row(), e_ft, e_sd})
        $display("FAIL swap_write t=%0d: got sel=%b row=%b ft=%b sd=%b want sel=%b row=%b ft=%b sd=%b",
                 t, a_sel, a_row, a_ft, a_sd, exp_sel(), exp_row(), e_ft, e_sd);
      else passed++;
      if (a_sd) begin
        checks++;
        if (a_ft !== 1'b1) $display("FAIL swap_with_tick: got ft=%b want 1", a_ft);
        else passed++;
      end
    end
    checks++;
    if (nsd !== 1 || !seen) $display("FAIL swap_once: got swaps=%0d seen=%0d want 1 1", nsd, seen);
    else passed++;
  endtask

  task automatic test_ignored_write();
    wr_en = 1; wr_col = 3'd7; wr_data = 5'b11111;
    tick();
    wr_en = 0; swap_req = 1;
    tick();
    swap_req = 0;
    repeat (2 * FR) begin
      tick();
      checks++;
      if (a_row === 5'b11111 || {a_sel, a_row, a_sd} !== {exp_sel(), exp_row(), e_sd})
        $display("FAIL ignored_write t=%0d: got sel=%b row=%b sd=%b want sel=%b row=%b sd=%b",
                 t, a_sel, a_row, a_sd, exp_sel(), exp_row(), e_sd);
      else passed++;
    end
  endtask

  task automatic test_en_drop();
    int guard;
    guard = 0;
    while (a_sel !== 3'b110 && guard < 2 * FR) begin tick(); guard++; end
    checks++;
    if (a_sel !== 3'b110) $display("FAIL en_drop_reach_col5: got sel=%b want 110", a_sel);
    else passed++;
    en = 0;
    tick();
    checks++;
    if ({a_sel, a_row} !== '0) $display("FAIL en_drop_dark: got sel=%b row=%b want 0", a_sel, a_row);
    else passed++;
    repeat (3) tick();
    en = 1;
    for (int i = 0; i < PER; i++) begin
      tick();
      checks++;
      if (a_sel !== ((i < P) ? 3'b001 : 3'b000) || a_sel !== exp_sel())
        $display("FAIL en_restart i=%0d: got sel=%b want %b", i, a_sel, exp_sel());
      else passed++;
    end
  endtask

  task automatic test_double_swap();
    int nsd, guard;
    nsd = 0; guard = 0;
    for (int c = 0; c < 7; c++) begin
      wr_en = 1; wr_col = 3'(c); wr_data = R'($urandom);
      tick();
    end
    wr_en = 0;
    while (a_sel !== 3'b010 && guard < 2 * FR) begin tick(); guard++; end
    swap_req = 1; tick(); nsd += a_sd;
    swap_req = 0; tick(); nsd += a_sd;
    swap_req = 1; tick(); nsd += a_sd;
    swap_req = 0;
    guard = 0;
    while (((t + 1) % FR) != 0 && guard < 2 * FR) begin tick(); nsd += a_sd; guard++; end
    swap_req = 1;
    repeat (FR + 1) begin
      tick();
      swap_req = 0;
      nsd += a_sd;
      checks++;
      if ({a_sel, a_row, a_ft, a_sd} !== {exp_sel(), exp_row(), e_ft, e_sd})
        $display("FAIL double_swap t=%0d: got sel=%b row=%b ft=%b sd=%b want sel=%b row=%b ft=%b sd=%b",
                 t, a_sel, a_row, a_ft, a_sd, exp_sel(), exp_row(), e_ft, e_sd);
      else passed++;
    end
    checks++;
    if (nsd !== 2) $display("FAIL double_swap_count: got %0d want 2", nsd);
    else passed++;
  endtask

  task automatic test_random();
    repeat (400) begin
      en       = ($urandom_range(0, 19) != 0);
      wr_en    = $urandom_range(0, 1);
      wr_col   = 3'($urandom);
      wr_data  = R'($urandom);
      swap_req = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if ({a_sel, a_row, a_ft, a_sd} !== {exp_sel(), exp_row(), e_ft, e_sd})
        $display("FAIL random t=%0d: got sel=%b row=%b ft=%b sd=%b want sel=%b row=%b ft=%b sd=%b",
                 t, a_sel, a_row, a_ft, a_sd, exp_sel(), exp_row(), e_ft, e_sd);
      else passed++;
    end
    en = 1; wr_en = 0; swap_req = 0;
  endtask

  task automatic test_no_blank();
    int nft;
    nft = 0;
    en1 = 1;
    repeat (2 * FR1 + 1) begin
      tick();
      nft += b_ft;
      checks++;
      if ({b_sel, b_ft} !== {exp_sel1(), e_ft1} || b_sel === 3'b000)
        $display("FAIL no_blank t=%0d: got sel=%b ft=%b want sel=%b ft=%b", t1, b_sel, b_ft, exp_sel1(), e_ft1);
      else passed++;
    end
    checks++;
    if (nft !== 2) $display("FAIL no_blank_tick_count: got %0d want 2", nft);
    else passed++;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while ((a_sel === 3'b000 || b_sel === 3'b000) && guard < 20) begin tick(); guard++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_sel, a_row, b_sel, b_row} !== '0)
      $display("FAIL async_reset: got a_sel=%b a_row=%b b_sel=%b want 0", a_sel, a_row, b_sel);
    else passed++;
    do_reset();
    checks++;
    if ({a_sel, a_row, a_ft, a_sd, b_sel} !== '0)
      $display("FAIL post_reset: got sel=%b row=%b ft=%b sd=%b want 0", a_sel, a_row, a_ft, a_sd);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_scan_sequence();
    test_swap_write();
    test_ignored_write();
    test_en_drop();
    test_double_swap();
    test_random();
    test_no_blank();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
